// File: rtl/datamover_s2mm_scheduler_if.sv
// Request, DataMover command/status and completion signals of the S2MM scheduler.
// master = scheduler side, slave = requester/DataMover/CSR side.
interface datamover_s2mm_scheduler_if;
  logic [63:0]  req_addr;
  logic [22:0]  req_btt;
  logic         req_valid;
  logic         req_ready;
  logic [103:0] m_axis_cmd_tdata;
  logic         m_axis_cmd_tvalid;
  logic         m_axis_cmd_tready;
  logic [7:0]   s_axis_sts_tdata;
  logic         s_axis_sts_tkeep;
  logic         s_axis_sts_tlast;
  logic         s_axis_sts_tvalid;
  logic         s_axis_sts_tready;
  logic         cmpl_valid;
  logic [3:0]   cmpl_tag;
  logic         cmpl_ok;

  modport master (
    input  req_addr, req_btt, req_valid, m_axis_cmd_tready,
           s_axis_sts_tdata, s_axis_sts_tkeep, s_axis_sts_tlast, s_axis_sts_tvalid,
    output req_ready, m_axis_cmd_tdata, m_axis_cmd_tvalid, s_axis_sts_tready,
           cmpl_valid, cmpl_tag, cmpl_ok
  );

  modport slave (
    output req_addr, req_btt, req_valid, m_axis_cmd_tready,
           s_axis_sts_tdata, s_axis_sts_tkeep, s_axis_sts_tlast, s_axis_sts_tvalid,
    input  req_ready, m_axis_cmd_tdata, m_axis_cmd_tvalid, s_axis_sts_tready,
           cmpl_valid, cmpl_tag, cmpl_ok
  );
endinterface

// File: rtl/datamover_s2mm_scheduler.sv
// S2MM DataMover command issuer with rolling tags, in-flight limit and
// status/completion tracking with sticky error reporting.
module datamover_s2mm_scheduler #(
  parameter int MAX_OUTSTANDING = 8
) (
  input  logic                              clk,
  input  logic                              resetn,
  datamover_s2mm_scheduler_if.master        bus,
  input  logic                              i_halt_on_err,
  input  logic                              i_clr_err,
  output logic [4:0]                        o_outstanding,
  output logic                              o_err_sticky,
  output logic                              o_tag_mismatch,
  output logic [15:0]                       o_err_count,
  output logic                              o_rejected,
  output logic                              o_idle
);

  localparam logic [4:0] LP_MAX = 5'(MAX_OUTSTANDING);

  logic [103:0] r_cmd_tdata;
  logic         r_cmd_tvalid;
  logic [3:0]   r_issue_tag;
  logic [3:0]   r_expect_tag;
  logic [4:0]   r_outstanding;
  logic         r_halted;
  logic         r_err_sticky;
  logic         r_tag_mismatch;
  logic [15:0]  r_err_count;
  logic         r_rejected;
  logic         r_cmpl_valid;
  logic [3:0]   r_cmpl_tag;
  logic         r_cmpl_ok;

  logic w_req_ready;
  logic w_req_hs;
  logic w_load;
  logic w_cmd_hs;
  logic w_sts_hs;
  logic w_sts_real;
  logic w_sts_err;
  logic w_tm_set;
  logic w_unused_sts;

  assign w_req_ready = resetn && !r_halted && (r_outstanding < LP_MAX) &&
                       (!r_cmd_tvalid || bus.m_axis_cmd_tready);
  assign w_req_hs    = bus.req_valid && w_req_ready;
  assign w_load      = w_req_hs && (bus.req_btt != 23'd0);
  assign w_cmd_hs    = r_cmd_tvalid && bus.m_axis_cmd_tready;
  assign w_sts_hs    = bus.s_axis_sts_tvalid && resetn;
  assign w_sts_real  = w_sts_hs && (r_outstanding != 5'd0);
  assign w_sts_err   = !bus.s_axis_sts_tdata[7] || (|bus.s_axis_sts_tdata[6:4]);
  // A status with nothing in flight is as suspicious as an out-of-order tag.
  assign w_tm_set    = w_sts_hs && ((r_outstanding == 5'd0) ||
                                    (bus.s_axis_sts_tdata[3:0] != r_expect_tag));
  assign w_unused_sts = bus.s_axis_sts_tkeep ^ bus.s_axis_sts_tlast;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cmd_tdata  <= '0;
      r_cmd_tvalid <= 1'b0;
      r_issue_tag  <= 4'd0;
    end else if (w_load) begin
      r_cmd_tdata  <= {4'b0, r_issue_tag, bus.req_addr, 1'b0, 1'b1, 6'b0, 1'b1, bus.req_btt};
      r_cmd_tvalid <= 1'b1;
      r_issue_tag  <= r_issue_tag + 4'd1;
    end else if (w_cmd_hs) begin
      r_cmd_tdata  <= '0;
      r_cmd_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_outstanding <= 5'd0;
      r_expect_tag  <= 4'd0;
    end else begin
      case ({w_load, w_sts_real})
        2'b10:   r_outstanding <= r_outstanding + 5'd1;
        2'b01:   r_outstanding <= r_outstanding - 5'd1;
        default: r_outstanding <= r_outstanding;
      endcase
      if (w_sts_real) r_expect_tag <= r_expect_tag + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_cmpl_valid <= 1'b0;
      r_cmpl_tag   <= 4'd0;
      r_cmpl_ok    <= 1'b0;
    end else begin
      r_cmpl_valid <= w_sts_real;
      if (w_sts_real) begin
        r_cmpl_tag <= bus.s_axis_sts_tdata[3:0];
        r_cmpl_ok  <= !w_sts_err;
      end
    end
  end

  // Set events take priority over a same-cycle clr_err so no error is lost.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_err_sticky   <= 1'b0;
      r_err_count    <= 16'd0;
      r_tag_mismatch <= 1'b0;
      r_rejected     <= 1'b0;
      r_halted       <= 1'b0;
    end else begin
      if (w_sts_hs && w_sts_err)      r_err_sticky <= 1'b1;
      else if (i_clr_err)             r_err_sticky <= 1'b0;

      if (i_clr_err)                  r_err_count <= (w_sts_hs && w_sts_err) ? 16'd1 : 16'd0;
      else if (w_sts_hs && w_sts_err && (r_err_count != 16'hFFFF))
                                      r_err_count <= r_err_count + 16'd1;

      if (w_tm_set)                   r_tag_mismatch <= 1'b1;
      else if (i_clr_err)             r_tag_mismatch <= 1'b0;

      if (w_req_hs && !w_load)        r_rejected <= 1'b1;
      else if (i_clr_err)             r_rejected <= 1'b0;

      if (w_sts_hs && w_sts_err && i_halt_on_err) r_halted <= 1'b1;
      else if (i_clr_err)             r_halted <= 1'b0;
    end
  end

  assign bus.req_ready         = w_req_ready;
  assign bus.m_axis_cmd_tdata  = r_cmd_tdata;
  assign bus.m_axis_cmd_tvalid = r_cmd_tvalid;
  assign bus.s_axis_sts_tready = resetn;
  assign bus.cmpl_valid        = r_cmpl_valid;
  assign bus.cmpl_tag          = r_cmpl_tag;
  assign bus.cmpl_ok           = r_cmpl_ok;

  assign o_outstanding  = r_outstanding;
  assign o_err_sticky   = r_err_sticky;
  assign o_tag_mismatch = r_tag_mismatch;
  assign o_err_count    = r_err_count;
  assign o_rejected     = r_rejected;
  assign o_idle         = (r_outstanding == 5'd0) && !r_cmd_tvalid;

endmodule

// File: tb/tb_datamover_s2mm_scheduler.sv
// Directed bench for datamover_s2mm_scheduler with command/completion scoreboards.
module tb_datamover_s2mm_scheduler;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        halt_on_err = 1'b0;
  logic        clr_err = 1'b0;
  logic [4:0]  outstanding;
  logic        err_sticky, tag_mismatch, rejected, idle;
  logic [15:0] err_count;

  int checks = 0;
  int failures = 0;
  int n_cmpl = 0;

  logic [103:0] cmd_q[$];
  logic [4:0]   cmpl_q[$];   // {ok, tag}
  int           m_out = 0;
  logic [3:0]   m_tag = 4'd0;
  logic [3:0]   b_expect;

  datamover_s2mm_scheduler_if bus ();

  datamover_s2mm_scheduler #(.MAX_OUTSTANDING(8)) dut (
    .clk(clk), .resetn(resetn), .bus(bus),
    .i_halt_on_err(halt_on_err), .i_clr_err(clr_err),
    .o_outstanding(outstanding), .o_err_sticky(err_sticky),
    .o_tag_mismatch(tag_mismatch), .o_err_count(err_count),
    .o_rejected(rejected), .o_idle(idle)
  );

  always #5 clk = ~clk;

  function automatic logic [103:0] mkcmd(input logic [3:0] tag, input logic [63:0] a,
                                         input logic [22:0] b);
    return {4'h0, tag, a, 2'b01, 6'h0, 1'b1, b};
  endfunction

  task automatic check(input string name, input logic [103:0] obs, input logic [103:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Scoreboard: compare what the DUT produced up to the last edge, then log the
  // handshakes that the next edge will take.
  always @(negedge clk) begin
    logic [4:0] e;
    logic [103:0] c;
    check("outstanding_track", outstanding, 5'(m_out));
    if (bus.cmpl_valid) begin
      if (cmpl_q.size() == 0) check("cmpl_unexpected", bus.cmpl_valid, 1'b0);
      else begin
        e = cmpl_q.pop_front();
        n_cmpl++;
        check("cmpl_tag", bus.cmpl_tag, e[3:0]);
        check("cmpl_ok", bus.cmpl_ok, e[4]);
      end
    end
    if (resetn && bus.m_axis_cmd_tvalid && bus.m_axis_cmd_tready) begin
      if (cmd_q.size() == 0) check("cmd_unexpected", bus.m_axis_cmd_tvalid, 1'b0);
      else begin
        c = cmd_q.pop_front();
        check("cmd_data", bus.m_axis_cmd_tdata, c);
      end
    end
    if (!resetn) begin
      m_out = 0;
      m_tag = 4'd0;
      cmd_q.delete();
      cmpl_q.delete();
    end else begin
      if (bus.req_valid && bus.req_ready && bus.req_btt != 23'd0) begin
        cmd_q.push_back(mkcmd(m_tag, bus.req_addr, bus.req_btt));
        m_tag = m_tag + 4'd1;
        m_out = m_out + 1;
      end
      if (bus.s_axis_sts_tvalid && m_out > 0 &&
          !(bus.req_valid && bus.req_ready && bus.req_btt != 23'd0 && m_out == 1 && 0)) begin
        cmpl_q.push_back({bus.s_axis_sts_tdata[7] && !(|bus.s_axis_sts_tdata[6:4]),
                          bus.s_axis_sts_tdata[3:0]});
        m_out = m_out - 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_req(input logic [63:0] a, input logic [22:0] b);
    bit done = 1'b0;
    bus.req_addr  = a;
    bus.req_btt   = b;
    bus.req_valid = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (bus.req_ready) done = 1'b1;
      tick();
    end
    bus.req_valid = 1'b0;
    check("req_accept", done, 1'b1);
  endtask

  task automatic send_sts(input logic [7:0] d);
    bus.s_axis_sts_tdata  = d;
    bus.s_axis_sts_tvalid = 1'b1;
    tick();
    bus.s_axis_sts_tvalid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clk);
      if (idle && cmpl_q.size() == 0 && !bus.cmpl_valid) done = 1'b1;
    end
    check(name, idle, 1'b1);
    tick();
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_addr = '0; bus.req_btt = '0; bus.req_valid = 1'b0;
    bus.m_axis_cmd_tready = 1'b1;
    bus.s_axis_sts_tdata = '0; bus.s_axis_sts_tkeep = 1'b1; bus.s_axis_sts_tlast = 1'b1;
    bus.s_axis_sts_tvalid = 1'b0;

    // Reset state
    repeat (3) tick();
    @(negedge clk);
    check("rst_req_ready", bus.req_ready, 1'b0);
    check("rst_sts_tready", bus.s_axis_sts_tready, 1'b0);
    check("rst_cmd_tvalid", bus.m_axis_cmd_tvalid, 1'b0);
    check("rst_cmd_tdata", bus.m_axis_cmd_tdata, 104'd0);
    check("rst_cmpl_valid", bus.cmpl_valid, 1'b0);
    check("rst_cmpl_tag", bus.cmpl_tag, 4'd0);
    check("rst_cmpl_ok", bus.cmpl_ok, 1'b0);
    check("rst_err_sticky", err_sticky, 1'b0);
    check("rst_err_count", err_count, 16'd0);
    check("rst_tag_mismatch", tag_mismatch, 1'b0);
    check("rst_rejected", rejected, 1'b0);
    check("rst_idle", idle, 1'b1);
    tick();
    resetn = 1'b1;
    @(negedge clk);
    check("post_rst_req_ready", bus.req_ready, 1'b1);
    tick();

    // Basic flow
    send_req(64'h1000, 23'd4096);
    @(negedge clk);
    check("basic_cmd0", bus.m_axis_cmd_tdata, mkcmd(4'd0, 64'h1000, 23'd4096));
    check("basic_out1", outstanding, 5'd1);
    tick();
    send_req(64'h2000, 23'd4096);
    send_req(64'h3000, 23'd4096);
    @(negedge clk);
    check("basic_out3", outstanding, 5'd3);
    tick();
    send_sts(8'h80);
    send_sts(8'h81);
    send_sts(8'h82);
    wait_idle("basic_idle");
    check("basic_out0", outstanding, 5'd0);
    check("basic_cmpl_count", n_cmpl, 3);

    // Backpressure and outstanding limit
    for (int i = 0; i < 8; i++) send_req(64'h10000 + 64'(i) * 64'h100, 23'd256);
    @(negedge clk);
    check("limit_req_ready", bus.req_ready, 1'b0);
    check("limit_out8", outstanding, 5'd8);
    tick();
    bus.m_axis_cmd_tready = 1'b0;
    bus.req_addr = 64'hABCD_0000; bus.req_btt = 23'd100; bus.req_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("limit_hold", bus.req_ready, 1'b0);
      tick();
    end
    send_sts(8'h83);
    @(negedge clk);
    check("limit_reopen", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("bp_tvalid", bus.m_axis_cmd_tvalid, 1'b1);
    check("bp_out8", outstanding, 5'd8);
    for (int i = 0; i < 5; i++) begin
      check("bp_stable", bus.m_axis_cmd_tdata, mkcmd(4'd11, 64'hABCD_0000, 23'd100));
      @(negedge clk);
    end
    tick();
    bus.m_axis_cmd_tready = 1'b1;
    b_expect = 4'd4;
    for (int i = 0; i < 8; i++) begin
      send_sts({4'h8, b_expect});
      b_expect = b_expect + 4'd1;
    end
    wait_idle("bp_idle");
    check("bp_no_mismatch", tag_mismatch, 1'b0);

    // Error with halt
    halt_on_err = 1'b1;
    send_req(64'h5000, 23'd64);
    send_sts({4'hC, b_expect});
    b_expect = b_expect + 4'd1;
    @(negedge clk);
    check("err_cmpl_valid", bus.cmpl_valid, 1'b1);
    check("err_cmpl_ok", bus.cmpl_ok, 1'b0);
    check("err_sticky", err_sticky, 1'b1);
    check("err_count1", err_count, 16'd1);
    check("err_halted", bus.req_ready, 1'b0);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    halt_on_err = 1'b0;
    @(negedge clk);
    check("clr_sticky", err_sticky, 1'b0);
    check("clr_count", err_count, 16'd0);
    check("clr_mismatch", tag_mismatch, 1'b0);
    check("clr_req_ready", bus.req_ready, 1'b1);
    tick();

    // Error status coinciding with clr_err
    send_req(64'h6000, 23'd64);
    bus.s_axis_sts_tdata = {4'hA, b_expect};
    bus.s_axis_sts_tvalid = 1'b1;
    clr_err = 1'b1;
    tick();
    bus.s_axis_sts_tvalid = 1'b0;
    clr_err = 1'b0;
    b_expect = b_expect + 4'd1;
    @(negedge clk);
    check("errclr_sticky", err_sticky, 1'b1);
    check("errclr_count", err_count, 16'd1);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Tag mismatch and spurious status
    send_req(64'h7000, 23'd8);
    send_sts(8'h85);
    b_expect = b_expect + 4'd1;
    @(negedge clk);
    check("tm_set", tag_mismatch, 1'b1);
    check("tm_cmpl_tag", bus.cmpl_tag, 4'd5);
    tick();
    wait_idle("tm_idle");
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    send_sts(8'h80);
    @(negedge clk);
    check("spur_mismatch", tag_mismatch, 1'b1);
    check("spur_no_cmpl", bus.cmpl_valid, 1'b0);
    check("spur_out0", outstanding, 5'd0);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    // Tag wrap over 20 request/status pairs
    for (int i = 0; i < 20; i++) begin
      send_req(64'h8000 + 64'(i) * 64'h40, 23'(i + 1));
      send_sts({4'h8, b_expect});
      b_expect = b_expect + 4'd1;
    end
    wait_idle("wrap_idle");
    check("wrap_no_mismatch", tag_mismatch, 1'b0);

    // Simultaneous request and status
    send_req(64'h9000, 23'd16);
    bus.req_addr = 64'h9100; bus.req_btt = 23'd16; bus.req_valid = 1'b1;
    bus.s_axis_sts_tdata = {4'h8, b_expect}; bus.s_axis_sts_tvalid = 1'b1;
    @(negedge clk);
    check("simul_ready", bus.req_ready, 1'b1);
    tick();
    bus.req_valid = 1'b0;
    bus.s_axis_sts_tvalid = 1'b0;
    b_expect = b_expect + 4'd1;
    @(negedge clk);
    check("simul_out1", outstanding, 5'd1);
    tick();
    send_sts({4'h8, b_expect});
    b_expect = b_expect + 4'd1;
    wait_idle("simul_idle");

    // Zero-length request
    send_req(64'hA000, 23'd0);
    @(negedge clk);
    check("zero_rejected", rejected, 1'b1);
    check("zero_no_cmd", bus.m_axis_cmd_tvalid, 1'b0);
    check("zero_out0", outstanding, 5'd0);
    tick();

    // Reset mid-operation
    send_req(64'hB000, 23'd32);
    send_req(64'hB100, 23'd32);
    tick();
    bus.m_axis_cmd_tready = 1'b0;
    send_req(64'hB200, 23'd32);
    @(negedge clk);
    check("mid_out3", outstanding, 5'd3);
    check("mid_tvalid", bus.m_axis_cmd_tvalid, 1'b1);
    tick();
    resetn = 1'b0;
    tick();
    @(negedge clk);
    check("mid_rst_tvalid", bus.m_axis_cmd_tvalid, 1'b0);
    check("mid_rst_tdata", bus.m_axis_cmd_tdata, 104'd0);
    check("mid_rst_out", outstanding, 5'd0);
    check("mid_rst_rejected", rejected, 1'b0);
    check("mid_rst_ready", bus.req_ready, 1'b0);
    check("mid_rst_idle", idle, 1'b1);
    tick();
    resetn = 1'b1;
    bus.m_axis_cmd_tready = 1'b1;
    tick();
    send_req(64'hC000, 23'd48);
    @(negedge clk);
    check("mid_tag0", bus.m_axis_cmd_tdata, mkcmd(4'd0, 64'hC000, 23'd48));
    tick();
    send_sts(8'h80);
    wait_idle("final_idle");
    check("final_cmd_q", cmd_q.size(), 0);
    check("final_mismatch", tag_mismatch, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/datamover_s2mm_scheduler.md
# datamover_s2mm_scheduler

Command issuer and completion tracker for an AXI DataMover S2MM channel. Accepts write requests (address, byte count) from an upstream requester, formats and issues 104-bit DataMover commands with rolling 4-bit tags, and bounds the number of in-flight transfers. It also consumes the 8-bit status stream, checks tag order and the OKAY/error bits, and reports per-transfer completions and error state to the control/status register block.

## Interface
Parameters:
- MAX_OUTSTANDING, 8, maximum accepted-but-uncompleted transfers; legal range 1..16.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- req_addr  in  64  destination byte address.
- req_btt  in  23  bytes to transfer; 0 is illegal and is rejected.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid && ready.
- m_axis_cmd_tdata  out  104  DataMover command.
- m_axis_cmd_tvalid  out  1  command valid.
- m_axis_cmd_tready  in  1  command ready.
- s_axis_sts_tdata  in  8  status: [7] OKAY, [6] SLVERR, [5] DECERR, [4] INTERR, [3:0] TAG.
- s_axis_sts_tkeep  in  1  ignored.
- s_axis_sts_tlast  in  1  ignored.
- s_axis_sts_tvalid  in  1  status valid.
- s_axis_sts_tready  out  1  equals resetn.
- cmpl_valid  out  1  one-cycle completion pulse.
- cmpl_tag  out  4  tag of the completed transfer.
- cmpl_ok  out  1  completed transfer had no error.
- halt_on_err  in  1  stop accepting requests after an error.
- clr_err  in  1  one-cycle pulse that clears error state.
- outstanding  out  5  accepted, uncompleted transfers.
- err_sticky  out  1  at least one error status since the last clear.
- tag_mismatch  out  1  sticky; out-of-order or spurious status seen.
- err_count  out  16  saturating count of error statuses.
- rejected  out  1  sticky; a request with btt==0 was dropped.
- idle  out  1  outstanding==0 && !m_axis_cmd_tvalid.

## Operation
- Command format, MSB to LSB: 4'b0 reserved, TAG[3:0], SADDR[63:0], DRR=0, EOF=1, DSA=6'b0, TYPE=1 (INCR), BTT[22:0].
- Command register: a single stage. It loads on a request handshake and clears on a cmd handshake that has no simultaneous load.
- req_ready = resetn && !halted && (outstanding < MAX_OUTSTANDING) && (!m_axis_cmd_tvalid || m_axis_cmd_tready). The expression is combinational.
- Accept with btt==0: the request is consumed, no command is issued, the tag and outstanding count do not change, and rejected is set.
- issue_tag starts at 0 and increments mod 16 on every accepted legal request.
- outstanding:
  - +1 on an accepted legal request.
  - -1 on a status handshake while outstanding>0.
  - Both events in the same cycle leave it unchanged.
- Status handshake (s_axis_sts_tvalid && resetn):
  - error = !sts[7] || |sts[6:4].
  - If outstanding==0, the status is spurious: set tag_mismatch, issue no cmpl pulse, leave the counter unchanged.
  - Otherwise, if sts[3:0] != expect_tag, set tag_mismatch. The completion is still reported using the received tag.
  - expect_tag increments mod 16 on every non-spurious status.
  - On error: set err_sticky, increment err_count (saturating at 16'hFFFF), and set halted if halt_on_err is high.
- clr_err clears err_sticky, err_count, tag_mismatch, rejected and halted. If an error status arrives in the same cycle, the error wins: err_sticky=1 and err_count=1.
- halted only blocks new requests. The command already in the register still drains, and statuses are still consumed.
- Reset mid-operation: all state returns to its reset value, the pending command is dropped and tags restart at 0. Software is responsible for resetting the DataMover in the same window.

## Timing
- Reset values are 0 for: req_ready, m_axis_cmd_tvalid, m_axis_cmd_tdata, cmpl_valid, cmpl_tag, cmpl_ok, outstanding, err_sticky, tag_mismatch, err_count, rejected, and internal halted/tags. idle=1 after reset.
- Request to command: m_axis_cmd_tvalid rises 1 cycle after the accept edge. With tready held high, throughput is 1 command per cycle.
- m_axis_cmd_tdata is stable while tvalid && !tready.
- Status to completion: cmpl_valid/cmpl_tag/cmpl_ok are registered 1 cycle after the status handshake. outstanding and the error outputs update on the same edge.
- The outstanding limit takes effect in the cycle outstanding reaches MAX_OUTSTANDING: req_ready is low that cycle. A status handshake in the same cycle reopens req_ready on the next cycle.

## Test plan
- Basic flow: 3 requests (addr 0x1000/0x2000/0x3000, btt 4096) with tready=1, then 3 OKAY statuses 0x80/0x81/0x82.
  - Required: cmd tags 0,1,2; cmd = {4'h0, tag, addr, 2'b01, 6'h0, 1'b1, 23'd4096}; outstanding 1→3→0; cmpl_ok=1 ×3; idle=1 at end.
- Backpressure/limit (MAX_OUTSTANDING=8):
  - 10 requests with no statuses returned: req_ready drops after 8 accepts and outstanding=8.
  - tready held low for 5 cycles: cmd data holds stable.
  - One status 0x80: a 9th request is accepted 1 cycle later.
- Error with halt: halt_on_err=1, status 0xC0 (SLVERR).
  - Required: cmpl_ok=0, err_sticky=1, err_count=1, req_ready=0.
  - After a clr_err pulse: all cleared and req_ready=1.
- Tag checks:
  - Status tag 5 while expecting tag 0: tag_mismatch=1, cmpl_tag=5.
  - Status while outstanding==0: tag_mismatch=1, no cmpl pulse, outstanding stays 0.
- Tag wrap and simultaneity:
  - 20 request/status pairs: tags wrap 15→0.
  - Request and status handshakes in the same cycle: outstanding unchanged.
  - btt=0 request: rejected=1, no cmd issued.
- Reset mid-operation: assert resetn=0 with 3 outstanding and cmd_tvalid=1. All outputs return to reset values, and the next command carries tag 0.
